// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared state, op-index and select-code definitions for the ALU op sequencer
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_0  = 4'd0;
    localparam logic [3:0] OP_1  = 4'd1;
    localparam logic [3:0] OP_2  = 4'd2;
    localparam logic [3:0] OP_3  = 4'd3;
    localparam logic [3:0] OP_4  = 4'd4;
    localparam logic [3:0] OP_5  = 4'd5;
    localparam logic [3:0] OP_6  = 4'd6;
    localparam logic [3:0] OP_7  = 4'd7;
    localparam logic [3:0] OP_8  = 4'd8;
    localparam logic [3:0] OP_9  = 4'd9;
    localparam logic [3:0] OP_10 = 4'd10;
    localparam logic [3:0] OP_LAST = OP_10;

    // Select codes are {S0,S1,S2,S3}; 0010 and 0100..0111 are never produced.
    localparam logic [3:0] SEL_0  = 4'b0000;
    localparam logic [3:0] SEL_1  = 4'b0001;
    localparam logic [3:0] SEL_2  = 4'b0011;
    localparam logic [3:0] SEL_3  = 4'b1000;
    localparam logic [3:0] SEL_4  = 4'b1001;
    localparam logic [3:0] SEL_5  = 4'b1010;
    localparam logic [3:0] SEL_6  = 4'b1011;
    localparam logic [3:0] SEL_7  = 4'b1100;
    localparam logic [3:0] SEL_8  = 4'b1101;
    localparam logic [3:0] SEL_9  = 4'b1110;
    localparam logic [3:0] SEL_10 = 4'b1111;

endpackage

// File: rtl/alu_sel_encode.sv
// rtl/alu_sel_encode.sv - combinational op index to sparse result-mux select code
module alu_sel_encode
    import alu_seq_pkg::*;
(
    input  logic [3:0] i_op,
    output logic [3:0] o_sel,
    output logic       o_illegal
);

    always_comb begin
        o_sel     = SEL_0;
        o_illegal = 1'b0;
        case (i_op)
            OP_0:    o_sel = SEL_0;
            OP_1:    o_sel = SEL_1;
            OP_2:    o_sel = SEL_2;
            OP_3:    o_sel = SEL_3;
            OP_4:    o_sel = SEL_4;
            OP_5:    o_sel = SEL_5;
            OP_6:    o_sel = SEL_6;
            OP_7:    o_sel = SEL_7;
            OP_8:    o_sel = SEL_8;
            OP_9:    o_sel = SEL_9;
            OP_10:   o_sel = SEL_10;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - issues an op to the ALU, waits WAIT_CYCLES, returns the captured result
// Optional illegal-request counter port err_cnt enabled by ALU_SEQ_ERRCNT_EN.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_s0,
    output logic              alu_s1,
    output logic              alu_s2,
    output logic              alu_s3,
    input  logic [DATA_W-1:0] alu_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_illegal,
    output logic              busy
`ifdef ALU_SEQ_ERRCNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("alu_op_sequencer: WAIT_CYCLES must be in 1..15");
    end

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [3:0]        r_sel;
    logic [DATA_W-1:0] r_out_result;
    logic              r_out_valid;
    logic              r_out_illegal;

    logic [3:0]        w_sel;
    logic              w_illegal;
    logic              w_accept;

    alu_sel_encode u_encode (
        .i_op      (in_op),
        .o_sel     (w_sel),
        .o_illegal (w_illegal)
    );

    assign w_accept = in_valid && (r_state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= 4'd0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_sel         <= SEL_0;
            r_out_result  <= '0;
            r_out_valid   <= 1'b0;
            r_out_illegal <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        // Illegal ops bypass the ALU so the last drive to the datapath is kept.
                        if (w_illegal) begin
                            r_out_result  <= '0;
                            r_out_illegal <= 1'b1;
                            r_out_valid   <= 1'b1;
                            r_state       <= DONE;
                        end else begin
                            r_alu_a <= in_a;
                            r_alu_b <= in_b;
                            r_sel   <= w_sel;
                            r_cnt   <= WAIT_CNT;
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_out_result  <= alu_result;
                        r_out_illegal <= 1'b0;
                        r_out_valid   <= 1'b1;
                        r_state       <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_ERRCNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= 8'd0;
        end else if (w_accept && w_illegal && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

    assign in_ready    = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_s0      = r_sel[3];
    assign alu_s1      = r_sel[2];
    assign alu_s2      = r_sel[1];
    assign alu_s3      = r_sel[0];
    assign out_valid   = r_out_valid;
    assign out_result  = r_out_result;
    assign out_illegal = r_out_illegal;

    logic w_unused;
    assign w_unused = w_accept;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer (WAIT_CYCLES 1 and 3 instances)
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with WAIT_CYCLES = 1
    logic       rst, in_valid, in_ready, out_valid, out_ready, out_illegal, busy;
    logic [3:0] in_op;
    logic [7:0] in_a, in_b, alu_a, alu_b, alu_result, out_result;
    logic       s0, s1, s2, s3;
`ifdef ALU_SEQ_ERRCNT_EN
    logic [7:0] err_cnt, err_cnt3;
`endif

    // Instance with WAIT_CYCLES = 3
    logic       rst3, in_valid3, in_ready3, out_valid3, out_ready3, out_illegal3, busy3;
    logic [3:0] in_op3;
    logic [7:0] in_a3, in_b3, alu_a3, alu_b3, alu_result3, out_result3;
    logic       t0, t1, t2, t3;

    assign alu_result  = alu_a + alu_b;
    assign alu_result3 = alu_a3 + alu_b3;

    alu_op_sequencer #(.DATA_W(8), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .alu_a(alu_a), .alu_b(alu_b),
        .alu_s0(s0), .alu_s1(s1), .alu_s2(s2), .alu_s3(s3), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_illegal(out_illegal), .busy(busy)
`ifdef ALU_SEQ_ERRCNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    alu_op_sequencer #(.DATA_W(8), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst3), .in_valid(in_valid3), .in_ready(in_ready3), .in_op(in_op3),
        .in_a(in_a3), .in_b(in_b3), .alu_a(alu_a3), .alu_b(alu_b3),
        .alu_s0(t0), .alu_s1(t1), .alu_s2(t2), .alu_s3(t3), .alu_result(alu_result3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_result(out_result3),
        .out_illegal(out_illegal3), .busy(busy3)
`ifdef ALU_SEQ_ERRCNT_EN
        , .err_cnt(err_cnt3)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] sel_of(input logic [3:0] op);
        case (op)
            4'd0:  return 4'b0000;
            4'd1:  return 4'b0001;
            4'd2:  return 4'b0011;
            4'd3:  return 4'b1000;
            4'd4:  return 4'b1001;
            4'd5:  return 4'b1010;
            4'd6:  return 4'b1011;
            4'd7:  return 4'b1100;
            4'd8:  return 4'b1101;
            4'd9:  return 4'b1110;
            4'd10: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    typedef struct packed {
        logic [7:0] res;
        logic       ill;
        logic [3:0] sel;
        logic [7:0] a;
        logic [7:0] b;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] m_sel = 4'b0000;
    logic [7:0] m_a   = 8'h00;
    logic [7:0] m_b   = 8'h00;

    // Pop and compare on each completed output handshake of the WAIT_CYCLES=1 instance.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("out_result", out_result, e.res);
                check("out_illegal", out_illegal, e.ill);
                check("alu_sel", {s0, s1, s2, s3}, e.sel);
                check("alu_a", alu_a, e.a);
                check("alu_b", alu_b, e.b);
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge where out_valid is first seen.
    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int   guard;
        int   lat;
        exp_t e;
        logic ill;
        ill = (op > 4'd10);
        in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 50) check("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!ill) begin
            m_sel = sel_of(op); m_a = a; m_b = b;
        end
        e.res = ill ? 8'h00 : 8'(a + b);
        e.ill = ill;
        e.sel = m_sel;
        e.a   = m_a;
        e.b   = m_b;
        sb_q.push_back(e);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        check(ill ? "lat_illegal" : "lat_legal", lat, ill ? 0 : 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hits;
        int lat3;
        logic [7:0] held;
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
        rst3 = 1'b1; in_valid3 = 1'b0; in_op3 = '0; in_a3 = '0; in_b3 = '0; out_ready3 = 1'b1;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_illegal", out_illegal, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_sel", {s0, s1, s2, s3}, 4'b0000);
        check("rst_busy", busy, 0);
        rst = 1'b0; rst3 = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_busy_after", busy, 0);
`ifdef ALU_SEQ_ERRCNT_EN
        check("rst_err_cnt", err_cnt, 0);
`endif

        // Basic legal op
        send(4'd2, 8'h12, 8'h34);
        check("op2_sel", {s0, s1, s2, s3}, 4'b0011);
        check("op2_result", out_result, 8'h46);
        @(posedge clk); #1;

        // Illegal op: selects and operands held, result zero
        send(4'd11, 8'hAA, 8'h55);
        check("ill_sel_held", {s0, s1, s2, s3}, 4'b0011);
        check("ill_a_held", alu_a, 8'h12);
`ifdef ALU_SEQ_ERRCNT_EN
        check("err_cnt_one", err_cnt, 1);
`endif
        @(posedge clk); #1;

        // Consumer stalls in DONE
        out_ready = 1'b0;
        send(4'd5, 8'h20, 8'h03);
        held = out_result;
        check("stall_result", held, 8'h23);
        in_valid = 1'b1; in_op = 4'd3; in_a = 8'hEE; in_b = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_valid", out_valid, 1);
            check("stall_hold", out_result, 8'h23);
            check("stall_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_hs_in_ready", in_ready, 1);
        check("post_hs_valid", out_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        check("no_ghost_busy", busy, 0);
        check("no_ghost_alu_a", alu_a, 8'h20);

        // Sweep every legal op
        for (int op = 0; op <= 10; op++) begin
            send(4'(op), 8'(op * 3), 8'h00);
            check("sweep_sel", {s0, s1, s2, s3}, sel_of(4'(op)));
            check("sweep_result", out_result, 32'(op * 3));
            @(posedge clk); #1;
        end

`ifdef ALU_SEQ_ERRCNT_EN
        for (int i = 0; i < 300; i++) begin
            send(4'(11 + (i % 5)), 8'(i), 8'h01);
            @(posedge clk); #1;
        end
        check("err_cnt_sat", err_cnt, 255);
`endif

        // WAIT_CYCLES = 3 instance: latency, then reset mid-wait
        in_op3 = 4'd4; in_a3 = 8'h05; in_b3 = 8'h06; in_valid3 = 1'b1;
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        lat3 = 0;
        while (!out_valid3 && lat3 < 50) begin
            @(posedge clk); #1; lat3++;
        end
        check("w3_latency", lat3, 3);
        check("w3_result", out_result3, 8'h0B);
        check("w3_sel", {t0, t1, t2, t3}, 4'b1001);
        @(posedge clk); #1;
        check("w3_in_ready", in_ready3, 1);

        in_op3 = 4'd7; in_a3 = 8'h01; in_b3 = 8'h02; in_valid3 = 1'b1;
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        @(posedge clk); #1;
        check("w3_busy_mid", busy3, 1);
        rst3 = 1'b1;
        @(posedge clk); #1;
        rst3 = 1'b0;
        check("w3_rst_busy", busy3, 0);
        check("w3_rst_sel", {t0, t1, t2, t3}, 4'b0000);
        check("w3_rst_in_ready", in_ready3, 1);
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid3) hits++;
            @(posedge clk); #1;
        end
        check("w3_no_out_valid", hits, 0);

        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
